phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/phase_sequencer_pkg.sv | 29 ++
 rtl/phase_sequencer_if.sv | 33 +++
 rtl/phase_sequencer_stall_watchdog.sv | 32 +++
 rtl/phase_sequencer.sv | 123 ++++++++++++
 tb/tb_phase_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: FSM state encoding, phase
// constants and the default memory-stall tolerance.
package phase_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_STEP = 3'd2,
    ST_HALT = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  typedef logic [2:0] phase_t;

  localparam phase_t PH0 = 3'd0;
  localparam phase_t PH1 = 3'd1;
  localparam phase_t PH2 = 3'd2;
  localparam phase_t PH3 = 3'd3;
  localparam phase_t PH4 = 3'd4;
  localparam phase_t PH5 = 3'd5;

  // Memory-stall cycles tolerated in phase 3 before the sequencer errors out.
  localparam logic [7:0] STALL_LIMIT_DEFAULT = 8'd255;

  function automatic logic is_active(state_e s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between the phase sequencer and its environment.
//   run, step       : execution requests (level / single-cycle pulse)
//   hlt             : halt flag from the instruction decoder
//   mem_e, mem_ready: phase-3 memory use and its completion handshake
//   phase           : current phase 0..5
//   running, halted, err : registered, mutually exclusive status
//   instr_count     : retired-instruction counter, CNT_W bits
// Modport master drives the requests; modport slave is the sequencer.
interface phase_sequencer_if #(parameter int CNT_W = 16);
  import phase_sequencer_pkg::*;

  logic             run;
  logic             step;
  logic             hlt;
  logic             mem_e;
  logic             mem_ready;
  phase_t           phase;
  logic             running;
  logic             halted;
  logic             err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output run, step, hlt, mem_e, mem_ready,
    input  phase, running, halted, err, instr_count
  );

  modport slave (
    input  run, step, hlt, mem_e, mem_ready,
    output phase, running, halted, err, instr_count
  );

endinterface

// File: rtl/phase_sequencer_stall_watchdog.sv
// Counts consecutive memory-stall cycles and flags a timeout.
//   clk, rst : clock, synchronous active-high reset
//   stall    : phase is being held waiting for memory this cycle
//   timeout  : this stalled cycle is the LIMIT-th in a row
// The count clears whenever the stall ends (phase 3 is left) or on timeout.
module stall_watchdog
  import phase_sequencer_pkg::*;
#(
  parameter logic [7:0] LIMIT = STALL_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic stall,
  output logic timeout
);

  logic [7:0] count_q;

  // Compare in 9 bits so count_q + 1 cannot wrap against LIMIT = 255.
  assign timeout = stall && (({1'b0, count_q} + 9'd1) >= {1'b0, LIMIT});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || !stall || timeout) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Instruction phase sequencer: steps the decoder through phases 0..5 per
// instruction, stalls phase 3 on memory, counts retired instructions and
// handles halt and stall-timeout terminal states.
//   clk, rst : clock, synchronous active-high reset
//   bus      : phase_sequencer_if slave (requests in, phase/status out)
// STALL_LIMIT sets the stall tolerance; CNT_W must match the interface.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter logic [7:0] STALL_LIMIT = STALL_LIMIT_DEFAULT,
  parameter int         CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  phase_sequencer_if.slave   bus
);

  state_e           state_q, state_d;
  phase_t           phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             hlt_seen_q, hlt_seen_d;
  logic             running_q, halted_q, err_q;
  logic             running_d, halted_d, err_d;
  logic             stall, timeout;

  assign stall = is_active(state_q) && (phase_q == PH3) && bus.mem_e && !bus.mem_ready;

  stall_watchdog #(.LIMIT(STALL_LIMIT)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .timeout (timeout)
  );

  // State register: reset wins over everything, so no partial retire counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH0;
      count_q    <= '0;
      hlt_seen_q <= 1'b0;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      hlt_seen_q <= hlt_seen_d;
      running_q  <= running_d;
      halted_q   <= halted_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    count_d    = count_q;
    hlt_seen_d = hlt_seen_q;

    unique case (state_q)
      ST_IDLE: begin
        phase_d    = PH0;
        hlt_seen_d = 1'b0;
        if (bus.run)       state_d = ST_RUN;
        else if (bus.step) state_d = ST_STEP;
      end

      ST_RUN, ST_STEP: begin
        // hlt is remembered from any of phases 1..5 and acted on at retire.
        if (bus.hlt && (phase_q != PH0)) hlt_seen_d = 1'b1;

        if (timeout) begin
          state_d    = ST_ERR;
          phase_d    = PH0;
          hlt_seen_d = 1'b0;
        end else begin
          case (phase_q)
            PH0, PH1, PH2, PH4: phase_d = phase_q + 3'd1;
            PH3:                if (!stall) phase_d = PH4;
            PH5: begin
              phase_d    = PH0;
              count_d    = count_q + CNT_W'(1);
              hlt_seen_d = 1'b0;
              if (hlt_seen_q || bus.hlt)             state_d = ST_HALT;
              else if (state_q == ST_STEP || !bus.run) state_d = ST_IDLE;
            end
            default: begin
              state_d    = ST_IDLE;
              phase_d    = PH0;
              hlt_seen_d = 1'b0;
            end
          endcase
        end
      end

      ST_HALT, ST_ERR: phase_d = PH0;

      default: begin
        state_d    = ST_IDLE;
        phase_d    = PH0;
        hlt_seen_d = 1'b0;
      end
    endcase
  end

  // Status outputs are decoded from the next state and registered alongside it.
  always_comb begin
    running_d = is_active(state_d);
    halted_d  = (state_d == ST_HALT);
    err_d     = (state_d == ST_ERR);
  end

  assign bus.phase       = phase_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.err         = err_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. Inputs change 1 ns after the rising
// edge and outputs are sampled at the same point, away from the edge.
// Instance dut uses the default stall limit; dut_lim uses STALL_LIMIT = 4.
module tb_phase_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  phase_sequencer_if #(.CNT_W(16)) b  ();
  phase_sequencer_if #(.CNT_W(16)) b4 ();

  phase_sequencer #(.STALL_LIMIT(8'd255), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (b)
  );

  phase_sequencer #(.STALL_LIMIT(8'd4), .CNT_W(16)) dut_lim (
    .clk (clk), .rst (rst), .bus (b4)
  );

  // Status vector {phase, running, halted, err}.
  function automatic logic [5:0] st();
    return {b.phase, b.running, b.halted, b.err};
  endfunction

  function automatic logic [5:0] st4();
    return {b4.phase, b4.running, b4.halted, b4.err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b.run = 1'b0;  b.step = 1'b0;  b.hlt = 1'b0;  b.mem_e = 1'b0;  b.mem_ready = 1'b0;
    b4.run = 1'b0; b4.step = 1'b0; b4.hlt = 1'b0; b4.mem_e = 1'b0; b4.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (st() !== 6'b000_000) begin
      errors++; $display("FAIL reset_status got=%b exp=%b", st(), 6'b000_000);
    end
    checks++;
    if (b.instr_count !== 16'd0) begin
      errors++; $display("FAIL reset_count got=%0d exp=0", b.instr_count);
    end
    checks++;
    if (st4() !== 6'b000_000) begin
      errors++; $display("FAIL reset_status_lim got=%b exp=%b", st4(), 6'b000_000);
    end
    tick();
    checks++;
    if (st() !== 6'b000_000) begin
      errors++; $display("FAIL idle_hold got=%b exp=%b", st(), 6'b000_000);
    end
  endtask

  task automatic test_run();
    do_reset();
    b.run = 1'b1;
    tick();
    for (int i = 0; i < 18; i++) begin
      logic [2:0] ep;
      ep = 3'(i % 6);
      checks++;
      if (st() !== {ep, 3'b100}) begin
        errors++; $display("FAIL run_seq[%0d] got=%b exp=%b", i, st(), {ep, 3'b100});
      end
      checks++;
      if (b.instr_count !== 16'(i / 6)) begin
        errors++; $display("FAIL run_cnt[%0d] got=%0d exp=%0d", i, b.instr_count, i / 6);
      end
      tick();
    end
    checks++;
    if (b.instr_count !== 16'd3 || st() !== 6'b000_100) begin
      errors++; $display("FAIL run_18 got cnt=%0d st=%b exp cnt=3 st=000100", b.instr_count, st());
    end
    // Drop run in phase 2: the instruction still finishes, then IDLE.
    tick(); tick();
    b.run = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (st() !== 6'b101_100) begin
      errors++; $display("FAIL run_drop_ph5 got=%b exp=%b", st(), 6'b101_100);
    end
    tick();
    checks++;
    if (st() !== 6'b000_000 || b.instr_count !== 16'd4) begin
      errors++; $display("FAIL run_drop_idle got st=%b cnt=%0d exp st=000000 cnt=4", st(), b.instr_count);
    end
  endtask

  task automatic test_run_step_priority();
    do_reset();
    b.run = 1'b1; b.step = 1'b1;
    tick();
    b.step = 1'b0;
    repeat (6) tick();
    checks++;
    if (st() !== 6'b000_100 || b.instr_count !== 16'd1) begin
      errors++; $display("FAIL run_step_prio got st=%b cnt=%0d exp st=000100 cnt=1", st(), b.instr_count);
    end
  endtask

  task automatic test_step();
    do_reset();
    b.step = 1'b1;
    tick();
    b.step = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] ep;
      ep = 3'(i);
      checks++;
      if (st() !== {ep, 3'b100}) begin
        errors++; $display("FAIL step_seq[%0d] got=%b exp=%b", i, st(), {ep, 3'b100});
      end
      b.step = (i == 2);
      tick();
    end
    b.step = 1'b0;
    checks++;
    if (st() !== 6'b000_000 || b.instr_count !== 16'd1) begin
      errors++; $display("FAIL step_done got st=%b cnt=%0d exp st=000000 cnt=1", st(), b.instr_count);
    end
    tick();
    checks++;
    if (st() !== 6'b000_000 || b.instr_count !== 16'd1) begin
      errors++; $display("FAIL step_stay_idle got st=%b cnt=%0d exp st=000000 cnt=1", st(), b.instr_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    b.run = 1'b1; b.mem_e = 1'b1; b.mem_ready = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (st() !== 6'b011_100 || b.instr_count !== 16'd0) begin
        errors++; $display("FAIL stall_hold[%0d] got st=%b cnt=%0d exp st=011100 cnt=0", i, st(), b.instr_count);
      end
      if (i == 4) b.mem_ready = 1'b1;
      tick();
    end
    checks++;
    if (st() !== 6'b100_100 || b.instr_count !== 16'd0) begin
      errors++; $display("FAIL stall_release got st=%b cnt=%0d exp st=100100 cnt=0", st(), b.instr_count);
    end
    tick();
    checks++;
    if (b.instr_count !== 16'd0) begin
      errors++; $display("FAIL stall_ph5_cnt got=%0d exp=0", b.instr_count);
    end
    tick();
    checks++;
    if (st() !== 6'b000_100 || b.instr_count !== 16'd1) begin
      errors++; $display("FAIL stall_retire got st=%b cnt=%0d exp st=000100 cnt=1", st(), b.instr_count);
    end
  endtask

  task automatic test_halt();
    do_reset();
    b.run = 1'b1;
    tick();
    b.hlt = 1'b1;             // sampled in phase 0: must be ignored
    tick();
    b.hlt = 1'b0;
    repeat (5) tick();
    checks++;
    if (st() !== 6'b000_100 || b.instr_count !== 16'd1) begin
      errors++; $display("FAIL hlt_ph0_ignored got st=%b cnt=%0d exp st=000100 cnt=1", st(), b.instr_count);
    end
    tick(); tick();
    b.hlt = 1'b1;             // sampled in phase 2
    tick();
    b.hlt = 1'b0;
    tick(); tick();
    checks++;
    if (st() !== 6'b101_100) begin
      errors++; $display("FAIL hlt_completes got=%b exp=%b", st(), 6'b101_100);
    end
    tick();
    checks++;
    if (st() !== 6'b000_010 || b.instr_count !== 16'd2) begin
      errors++; $display("FAIL hlt_enter got st=%b cnt=%0d exp st=000010 cnt=2", st(), b.instr_count);
    end
    b.run = 1'b1; b.step = 1'b1; b.mem_ready = 1'b1;
    repeat (3) tick();
    b.step = 1'b0;
    checks++;
    if (st() !== 6'b000_010 || b.instr_count !== 16'd2) begin
      errors++; $display("FAIL hlt_sticky got st=%b cnt=%0d exp st=000010 cnt=2", st(), b.instr_count);
    end
  endtask

  task automatic test_stall_timeout();
    do_reset();
    // Ready arriving on the 4th stalled sample avoids the error.
    b4.run = 1'b1; b4.mem_e = 1'b1; b4.mem_ready = 1'b0;
    repeat (4) tick();
    repeat (3) tick();
    checks++;
    if (st4() !== 6'b011_100) begin
      errors++; $display("FAIL lim_near got=%b exp=%b", st4(), 6'b011_100);
    end
    b4.mem_ready = 1'b1;
    tick();
    checks++;
    if (st4() !== 6'b100_100) begin
      errors++; $display("FAIL lim_just_ok got=%b exp=%b", st4(), 6'b100_100);
    end
    // Ready never comes: error after 4 stalled cycles.
    do_reset();
    b4.run = 1'b1; b4.mem_e = 1'b1; b4.mem_ready = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (st4() !== 6'b011_100) begin
        errors++; $display("FAIL lim_stall[%0d] got=%b exp=%b", i, st4(), 6'b011_100);
      end
      tick();
    end
    checks++;
    if (st4() !== 6'b000_001) begin
      errors++; $display("FAIL lim_err got=%b exp=%b", st4(), 6'b000_001);
    end
    b4.mem_ready = 1'b1; b4.step = 1'b1;
    repeat (2) tick();
    b4.step = 1'b0;
    checks++;
    if (st4() !== 6'b000_001 || b4.instr_count !== 16'd0) begin
      errors++; $display("FAIL lim_err_sticky got st=%b cnt=%0d exp st=000001 cnt=0", st4(), b4.instr_count);
    end
    do_reset();
    checks++;
    if (st4() !== 6'b000_000) begin
      errors++; $display("FAIL lim_err_clear got=%b exp=%b", st4(), 6'b000_000);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b.run = 1'b1;
    tick();
    repeat (46) tick();
    checks++;
    if (st() !== 6'b100_100 || b.instr_count !== 16'd7) begin
      errors++; $display("FAIL mid_setup got st=%b cnt=%0d exp st=100100 cnt=7", st(), b.instr_count);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (st() !== 6'b000_000 || b.instr_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset got st=%b cnt=%0d exp st=000000 cnt=0", st(), b.instr_count);
    end
    rst = 1'b0; b.run = 1'b0;
    tick();
    checks++;
    if (st() !== 6'b000_000 || b.instr_count !== 16'd0) begin
      errors++; $display("FAIL mid_after got st=%b cnt=%0d exp st=000000 cnt=0", st(), b.instr_count);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_run();
    test_run_step_priority();
    test_step();
    test_stall();
    test_halt();
    test_stall_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
